// File: rtl/ip_tx_arbiter_if.sv
// ip_tx_arbiter_if: requester, IP-layer and status signals of the IP transmit arbiter
interface ip_tx_arbiter_if;
  logic icmp_tx_req;
  logic icmp_tx_ready;
  logic [7:0] icmp_tx_data;
  logic [15:0] icmp_data_length;
  logic icmp_tx_ack;
  logic icmp_data_req;
  logic icmp_send_end;
  logic udp_tx_req;
  logic udp_tx_ready;
  logic [7:0] udp_tx_data;
  logic [15:0] udp_data_length;
  logic udp_tx_ack;
  logic udp_data_req;
  logic udp_send_end;
  logic ip_tx_req;
  logic ip_tx_ack;
  logic ip_data_req;
  logic ip_tx_ready;
  logic [7:0] ip_tx_data;
  logic [15:0] ip_data_length;
  logic [7:0] ip_protocol;
  logic mac_send_end;
  logic busy;
  modport master (
    input icmp_tx_req, icmp_tx_ready, icmp_tx_data, icmp_data_length,
    input udp_tx_req, udp_tx_ready, udp_tx_data, udp_data_length,
    input ip_tx_ack, ip_data_req, mac_send_end,
    output icmp_tx_ack, icmp_data_req, icmp_send_end,
    output udp_tx_ack, udp_data_req, udp_send_end,
    output ip_tx_req, ip_tx_ready, ip_tx_data, ip_data_length, ip_protocol, busy
  );
  modport slave (
    output icmp_tx_req, icmp_tx_ready, icmp_tx_data, icmp_data_length,
    output udp_tx_req, udp_tx_ready, udp_tx_data, udp_data_length,
    output ip_tx_ack, ip_data_req, mac_send_end,
    input icmp_tx_ack, icmp_data_req, icmp_send_end,
    input udp_tx_ack, udp_data_req, udp_send_end,
    input ip_tx_req, ip_tx_ready, ip_tx_data, ip_data_length, ip_protocol, busy
  );
endinterface

// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter: round-robin sharing of the IP transmit path between ICMP (port 0) and UDP (port 1)
module ip_tx_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'hFFFF,
  parameter logic [7:0] ICMP_PROTO = 8'd1,
  parameter logic [7:0] UDP_PROTO = 8'd17
) (
  input logic clk,
  input logic rst,
  ip_tx_arbiter_if.master bus
);
  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    GRANT   = 4'b0010,
    XFER    = 4'b0100,
    RELEASE = 4'b1000
  } state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, last_q, last_d;
  logic [15:0] len_q, len_d, cnt_q, cnt_d;
  logic [7:0] proto_q, proto_d;
  logic win, timeout, in_grant, in_xfer;
  // on a tie the port that did not win last time gets the frame
  assign win = (bus.icmp_tx_req & bus.udp_tx_req) ? ~last_q : bus.udp_tx_req;
  assign timeout = cnt_q == TIMEOUT - 16'd1;
  assign in_grant = state_q == GRANT;
  assign in_xfer = state_q == XFER;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q <= 1'b1;
      len_q <= '0;
      proto_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      len_q <= len_d;
      proto_q <= proto_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    len_d = len_q;
    proto_d = proto_q;
    case (state_q)
      IDLE: if (bus.icmp_tx_req | bus.udp_tx_req) begin
        state_d = GRANT;
        grant_d = win;
        len_d = win ? bus.udp_data_length : bus.icmp_data_length;
        proto_d = win ? UDP_PROTO : ICMP_PROTO;
      end
      GRANT: state_d = bus.ip_tx_ack ? XFER : (timeout ? RELEASE : GRANT);
      XFER: state_d = (bus.mac_send_end | timeout) ? RELEASE : XFER;
      RELEASE: begin
        state_d = IDLE;
        last_d = grant_q;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? 16'd0 : ((in_grant | in_xfer) ? cnt_q + 16'd1 : cnt_q);
  end
  assign bus.ip_tx_req = in_grant;
  assign bus.busy = state_q != IDLE;
  assign bus.icmp_tx_ack = in_grant & ~grant_q & bus.ip_tx_ack;
  assign bus.udp_tx_ack = in_grant & grant_q & bus.ip_tx_ack;
  assign bus.icmp_data_req = in_xfer & ~grant_q & bus.ip_data_req;
  assign bus.udp_data_req = in_xfer & grant_q & bus.ip_data_req;
  assign bus.icmp_send_end = in_xfer & ~grant_q & bus.mac_send_end;
  assign bus.udp_send_end = in_xfer & grant_q & bus.mac_send_end;
  assign bus.ip_tx_ready = in_xfer & (grant_q ? bus.udp_tx_ready : bus.icmp_tx_ready);
  assign bus.ip_tx_data = in_xfer ? (grant_q ? bus.udp_tx_data : bus.icmp_tx_data) : 8'h00;
  assign bus.ip_data_length = len_q;
  assign bus.ip_protocol = proto_q;
endmodule

// File: doc/ip_tx_arbiter.md
Name: ip_tx_arbiter

Overview:
- Shares the single IP-layer transmit path between two requesters: the ICMP echo-reply engine (port 0) and the UDP transmitter (port 1).
- Sits between those engines and the IP/MAC transmit stack.
- Grants one requester per frame, round-robin, and routes ack, data-request and send-end strobes to the granted requester only.
- Muxes the granted requester's data, ready, length and protocol onto the IP layer.
- Recovers from stalled frames via timeouts.

Parameters:
- TIMEOUT, 16'hFFFF, cycles allowed in GRANT or XFER before forced release.
- ICMP_PROTO, 8'd1, IP protocol number driven for port 0.
- UDP_PROTO, 8'd17, IP protocol number driven for port 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- icmp_tx_req  in  1  ICMP frame request; level, held until icmp_tx_ack
- icmp_tx_ready  in  1  ICMP payload ready
- icmp_tx_data  in  8  ICMP payload byte
- icmp_data_length  in  16  ICMP length, bytes
- icmp_tx_ack  out  1  ip_tx_ack routed to port 0
- icmp_data_req  out  1  ip_data_req routed to port 0
- icmp_send_end  out  1  mac_send_end routed to port 0
- udp_tx_req  in  1  UDP frame request; level, held until udp_tx_ack
- udp_tx_ready  in  1  UDP payload ready
- udp_tx_data  in  8  UDP payload byte
- udp_data_length  in  16  UDP length, bytes
- udp_tx_ack  out  1  ip_tx_ack routed to port 1
- udp_data_req  out  1  ip_data_req routed to port 1
- udp_send_end  out  1  mac_send_end routed to port 1
- ip_tx_req  out  1  frame request to IP layer
- ip_tx_ack  in  1  IP layer accepted request
- ip_data_req  in  1  IP layer requests payload
- ip_tx_ready  out  1  muxed ready
- ip_tx_data  out  8  muxed data
- ip_data_length  out  16  latched length of granted frame
- ip_protocol  out  8  latched protocol of granted frame
- mac_send_end  in  1  frame fully transmitted by MAC
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; grant=0; last_grant=1 (ICMP wins first tie); all outputs 0.
- States: IDLE, GRANT, XFER, RELEASE. One-hot encoding. Registered state, combinational next-state.
- IDLE, when neither request is pending: stay in IDLE.
- IDLE, when one or both requests are pending:
  - If only one requester is high, grant it.
  - If both are high, grant the one that is not last_grant.
  - Latch grant, ip_data_length and ip_protocol from the winner.
  - Set ip_tx_req=1 on the next cycle, then go to GRANT.
- Latched values ip_data_length and ip_protocol are constant from GRANT entry until the return to IDLE.
- GRANT, hold ip_tx_req=1:
  - On ip_tx_ack=1: pulse the granted xxx_tx_ack that same cycle (combinational route), clear ip_tx_req next cycle, go to XFER.
  - If the timeout counter reaches TIMEOUT-1 without ack: go to RELEASE.
- XFER:
  - ip_tx_ready, ip_tx_data and ip_data_req are combinationally routed by grant. There is zero added latency, so the requester's data timing relative to ip_data_req is unchanged.
  - On mac_send_end=1: pulse the granted xxx_send_end the same cycle, go to RELEASE.
  - On timeout: go to RELEASE with no send_end pulse.
- RELEASE: one cycle. last_grant<=grant. Go to IDLE.
  - This gives at least one idle cycle between frames, so a requester deasserting its req has a cycle to settle.
- Non-granted requester outputs (tx_ack, data_req, send_end) stay 0 at all times. ip_tx_ready and ip_tx_data are 0 outside XFER.
- Timeout counter: 16 bit, cleared on every state change, increments only in GRANT and XFER. Saturation is irrelevant because the transition fires at TIMEOUT-1.
- ip_tx_ack or mac_send_end arriving in IDLE or RELEASE is ignored; nothing is routed.
- A request arriving mid-frame waits. It is served after RELEASE with fairness applied.
- A requester deasserting its req while in GRANT still leaves the grant held. Only ack or timeout ends GRANT.
- A requester asserting req for consecutive frames while the other is idle is granted back-to-back, each separated by RELEASE.
- Async rst mid-frame aborts immediately to the reset values. No send_end is emitted.

Test Plan:
- Single ICMP: icmp_tx_req=1, length 16'd40, ack after 3 cycles, mac_send_end after 60 cycles.
  → ip_tx_req high from the cycle after IDLE; ip_protocol=1, ip_data_length=40; icmp_tx_ack and icmp_send_end are 1-cycle pulses; udp_* outputs all 0; busy drops 2 cycles after mac_send_end.
- Simultaneous icmp_tx_req and udp_tx_req after reset.
  → ICMP granted first (ip_protocol=1). After its RELEASE, UDP is granted (ip_protocol=17, its length). Then, with both asserted again, ICMP is granted (alternation holds).
- Data muxing in XFER: UDP granted, udp_tx_data increments 0x00..0x1F on ip_data_req.
  → ip_tx_data equals udp_tx_data the same cycle; icmp_tx_data=0xAA never appears; icmp_data_req stays 0.
- Ack timeout with TIMEOUT=16: request without ip_tx_ack.
  → RELEASE entered after 16 GRANT cycles; no tx_ack pulse; busy falls; a later request is served normally.
- Stray strobes: mac_send_end and ip_tx_ack pulsed in IDLE.
  → no routed pulses, state stays IDLE.
- Reset mid-XFER: rst=1 for 1 cycle during a UDP frame.
  → all outputs 0 immediately; state IDLE; next simultaneous request grants ICMP.
